// File: rtl/tqvp_rng_pkg.sv
// Shared constants for the TinyQV RNG peripheral: register addresses,
// status/control bit positions and the packed status byte layout.
package tqvp_rng_pkg;

  localparam logic [1:0] RNG_ADDR_DATA = 2'd0;
  localparam logic [1:0] RNG_ADDR_STAT = 2'd1;

  localparam int STAT_UNDERFLOW = 7;
  localparam int STAT_PENDING   = 6;
  localparam int STAT_FULL      = 5;
  localparam int STAT_EMPTY     = 4;

  localparam int CTRL_WHITEN = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_CLR_UF = 7;

  typedef struct packed {
    logic       underflow;
    logic       pending;
    logic       full;
    logic       empty;
    logic [3:0] count;
  } rng_status_t;

endpackage

// File: rtl/rng_byte_fifo_mem.sv
// DEPTH x 8 byte FIFO with power-of-two wrapping pointers and an explicit count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rng_byte_fifo_mem #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       push_ok
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_ok_s;

  assign empty    = (count_r == '0);
  assign full     = (count_r == CW'(DEPTH));
  assign pop_ok_s = pop & ~empty & ~flush;
  assign push_ok  = push & ~flush & (~full | pop_ok_s);
  assign head     = mem_r[rd_ptr_r];
  assign count    = 5'(count_r);

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok)  wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Byte storage; contents behind the read pointer are never observed when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/tqvp_rng_byte_fifo.sv
// LFSR bit stream -> optional von Neumann debias -> MSB-first byte packer -> FIFO,
// exposed to the TinyQV core as a data/status/control register block.
module tqvp_rng_byte_fifo
  import tqvp_rng_pkg::*;
#(
  parameter int   DEPTH      = 4,
  parameter logic WHITEN_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rnd_bit,
  input  logic       rnd_valid,
  output logic       rnd_ready,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic       data_read,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       fifo_nonempty
);

  logic [1:0]  reg_addr_s;
  logic        accept_s, ctrl_wr_s, flush_s, pop_s;
  logic        emit_s, emit_bit_s, half_next_s, first_next_s;
  logic        complete_s, push_s, push_ok_s;
  logic        pending_next_s, hold_load_s, underflow_next_s;
  logic [7:0]  byte_s, push_data_s, head_s;
  logic [4:0]  count_s;
  logic        full_s, empty_s;
  rng_status_t status_s;
  logic        unused_s;

  logic        whiten_r, half_r, first_r, pending_r, underflow_r, rnd_ready_r;
  logic [7:0]  shift_r, hold_r;
  logic [2:0]  bit_cnt_r;

  assign reg_addr_s = address[1:0];
  assign accept_s   = rnd_valid & rnd_ready_r;
  assign ctrl_wr_s  = data_write & (reg_addr_s == RNG_ADDR_STAT);
  assign flush_s    = ctrl_wr_s & data_in[CTRL_FLUSH];
  assign pop_s      = data_read & (reg_addr_s == RNG_ADDR_DATA);
  assign unused_s   = ^{address[3:2], data_in[6:2], count_s[4]};

  // Whitener: pair tracking and the bit handed to the packer this cycle.
  always_comb begin
    emit_s       = 1'b0;
    emit_bit_s   = rnd_bit;
    half_next_s  = half_r;
    first_next_s = first_r;
    if (accept_s) begin
      if (whiten_r) begin
        if (half_r) begin
          emit_s      = first_r ^ rnd_bit;
          emit_bit_s  = first_r;
          half_next_s = 1'b0;
        end else begin
          first_next_s = rnd_bit;
          half_next_s  = 1'b1;
        end
      end else begin
        emit_s = 1'b1;
      end
    end else begin
      emit_s = 1'b0;
    end
    // Any control write restarts pairing so a stale first bit is never paired.
    if (ctrl_wr_s) half_next_s = 1'b0;
    else           half_next_s = half_next_s;
  end

  assign byte_s      = {shift_r[6:0], emit_bit_s};
  assign complete_s  = emit_s & (bit_cnt_r == 3'd7) & ~flush_s;
  assign push_s      = pending_r | complete_s;
  assign push_data_s = pending_r ? hold_r : byte_s;

  // Hold-register, pending and underflow next-state.
  always_comb begin
    pending_next_s   = pending_r;
    hold_load_s      = 1'b0;
    underflow_next_s = underflow_r;
    if (flush_s) begin
      pending_next_s = 1'b0;
    end else if (pending_r) begin
      pending_next_s = ~push_ok_s;
    end else begin
      pending_next_s = complete_s & ~push_ok_s;
      hold_load_s    = complete_s & ~push_ok_s;
    end
    if (ctrl_wr_s && data_in[CTRL_CLR_UF]) begin
      underflow_next_s = 1'b0;
    end else if (pop_s && empty_s && !flush_s) begin
      underflow_next_s = 1'b1;
    end else begin
      underflow_next_s = underflow_r;
    end
  end

  // Control, whitener, packer and back-pressure state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      whiten_r    <= WHITEN_RST;
      half_r      <= 1'b0;
      first_r     <= 1'b0;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      hold_r      <= 8'h00;
      pending_r   <= 1'b0;
      underflow_r <= 1'b0;
      rnd_ready_r <= 1'b1;
    end else begin
      if (ctrl_wr_s) whiten_r <= data_in[CTRL_WHITEN];
      first_r     <= first_next_s;
      pending_r   <= pending_next_s;
      underflow_r <= underflow_next_s;
      rnd_ready_r <= ~pending_next_s;
      if (hold_load_s) hold_r <= byte_s;
      if (flush_s) begin
        half_r    <= 1'b0;
        shift_r   <= 8'h00;
        bit_cnt_r <= 3'd0;
      end else begin
        half_r <= half_next_s;
        if (emit_s) begin
          shift_r   <= byte_s;
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
      end
    end
  end

  rng_byte_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s),
    .push_ok   (push_ok_s)
  );

  assign status_s.underflow = underflow_r;
  assign status_s.pending   = pending_r;
  assign status_s.full      = full_s;
  assign status_s.empty     = empty_s;
  assign status_s.count     = count_s[3:0];

  // Register read mux.
  always_comb begin
    data_out = 8'h00;
    case (reg_addr_s)
      RNG_ADDR_DATA: data_out = empty_s ? 8'h00 : head_s;
      RNG_ADDR_STAT: data_out = status_s;
      default:       data_out = 8'h00;
    endcase
  end

  assign rnd_ready     = rnd_ready_r;
  assign fifo_nonempty = ~empty_s;

endmodule

// File: tb/tb_tqvp_rng_byte_fifo.sv
// Directed bench for tqvp_rng_byte_fifo: a per-cycle vector table plus
// hand-written stall, wrap and reset sequences.
module tb_tqvp_rng_byte_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rnd_bit, rnd_valid, rnd_ready;
  logic [3:0] address;
  logic       data_write, data_read;
  logic [7:0] data_in, data_out;
  logic       fifo_nonempty;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       b;
    logic       v;
    logic [3:0] a;
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [7:0] eo;
    logic       er;
    logic       en;
  } vec_t;

  vec_t tbl[$];

  tqvp_rng_byte_fifo #(.DEPTH(4), .WHITEN_RST(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rnd_bit       (rnd_bit),
    .rnd_valid     (rnd_valid),
    .rnd_ready     (rnd_ready),
    .address       (address),
    .data_write    (data_write),
    .data_read     (data_read),
    .data_in       (data_in),
    .data_out      (data_out),
    .fifo_nonempty (fifo_nonempty)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic b, input logic v, input logic [3:0] a,
                              input logic w, input logic r, input logic [7:0] d,
                              input logic [7:0] eo, input logic en);
    vec_t x;
    x.b = b; x.v = v; x.a = a; x.w = w; x.r = r; x.d = d;
    x.eo = eo; x.er = 1'b1; x.en = en;
    tbl.push_back(x);
  endfunction

  // Outputs are compared #1 after the falling edge, before the next rising edge.
  task automatic drive(input logic b, input logic v, input logic [3:0] a,
                       input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    rnd_bit = b; rnd_valid = v; address = a;
    data_write = w; data_read = r; data_in = d;
    #1;
  endtask

  task automatic chk8(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] data_out got=%02h want=%02h", nm, idx, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0b want=%0b", nm, idx, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input int idx, input logic [7:0] eo,
                            input logic er, input logic en);
    chk8(nm, idx, data_out, eo);
    chk1({nm, ".ready"}, idx, rnd_ready, er);
    chk1({nm, ".nonempty"}, idx, fifo_nonempty, en);
  endtask

  task automatic send_byte(input logic [7:0] bt, input string nm);
    for (int i = 7; i >= 0; i--) begin
      drive(bt[i], 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
      chk1({nm, ".ready"}, i, rnd_ready, 1'b1);
    end
  endtask

  task automatic idle_stat(input string nm, input logic [7:0] eo, input logic er, input logic en);
    drive(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00);
    expect_out(nm, 0, eo, er, en);
  endtask

  task automatic pop_exp(input string nm, input int idx, input logic [7:0] eo);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    expect_out(nm, idx, eo, 1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0]  pat;
    logic [19:0] pairs;
    logic [7:0]  bt;
    logic [7:0]  wrap_exp [4];

    rst_n = 1'b0; rnd_bit = 1'b0; rnd_valid = 1'b0; address = 4'd0;
    data_write = 1'b0; data_read = 1'b0; data_in = 8'h00;

    // Whiten off, A5 packed MSB-first, one pop.
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    add(0, 0, 4'd1, 1, 0, 8'h00, 8'h10, 0);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) add(pat[i], 1, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h01, 1);
    add(0, 0, 4'd0, 0, 1, 8'h00, 8'hA5, 1);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    // Whiten on: pairs 10,01,00,10,11,01,10,01,10,01 give AA.
    add(0, 0, 4'd1, 1, 0, 8'h01, 8'h10, 0);
    pairs = 20'h92D99;
    for (int i = 19; i >= 0; i--) add(pairs[i], 1, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h01, 1);
    add(0, 0, 4'd0, 0, 1, 8'h00, 8'hAA, 1);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    // Empty read sets underflow; writing 0x80 clears it and turns whitening off.
    add(0, 0, 4'd0, 0, 1, 8'h00, 8'h00, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h90, 0);
    add(0, 0, 4'd1, 1, 0, 8'h80, 8'h90, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    // Five bits, underflow, flush (underflow kept), then a clean 0x33.
    for (int i = 0; i < 5; i++) add(1, 1, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    add(0, 0, 4'd0, 0, 1, 8'h00, 8'h00, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h90, 0);
    add(0, 0, 4'd1, 1, 0, 8'h02, 8'h90, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h90, 0);
    pat = 8'h33;
    for (int i = 7; i >= 0; i--) add(pat[i], 1, 4'd1, 0, 0, 8'h00, 8'h90, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h81, 1);
    add(0, 0, 4'd0, 0, 1, 8'h00, 8'h33, 1);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h90, 0);
    add(0, 0, 4'd1, 1, 0, 8'h80, 8'h90, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    // Flush on the completing bit discards the byte; the next byte is clean.
    for (int i = 0; i < 7; i++) add(1, 1, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    add(1, 1, 4'd1, 1, 0, 8'h02, 8'h10, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    pat = 8'h5A;
    for (int i = 7; i >= 0; i--) add(pat[i], 1, 4'd1, 0, 0, 8'h00, 8'h10, 0);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h01, 1);
    add(0, 0, 4'd0, 0, 1, 8'h00, 8'h5A, 1);
    add(0, 0, 4'd1, 0, 0, 8'h00, 8'h10, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].b, tbl[i].v, tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].d);
      expect_out("tbl", i, tbl[i].eo, tbl[i].er, tbl[i].en);
    end

    // 40 bits with no reads: FIFO full plus one held byte, stream stalled.
    for (int k = 0; k < 5; k++) begin
      bt = 8'h11 * 8'(k + 1);
      send_byte(bt, "fill");
    end
    idle_stat("stall_stat", 8'h64, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
      expect_out("stall_hold", i, 8'h64, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    expect_out("stall_pop", 0, 8'h11, 1'b0, 1'b1);
    idle_stat("refill_stat", 8'h24, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) begin
      bt = 8'h11 * 8'(k + 1);
      pop_exp("drain", k, bt);
    end
    idle_stat("drain_stat", 8'h10, 1'b1, 1'b0);

    // Pop coinciding with byte completion while full: no stall, order kept over wrap.
    send_byte(8'h61, "wrap"); send_byte(8'h72, "wrap");
    send_byte(8'h83, "wrap"); send_byte(8'h94, "wrap");
    idle_stat("wrap_full", 8'h24, 1'b1, 1'b1);
    pat = 8'hC7;
    for (int i = 7; i >= 1; i--) begin
      drive(pat[i], 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
      chk1("wrap_c7.ready", i, rnd_ready, 1'b1);
    end
    drive(pat[0], 1'b1, 4'd0, 1'b0, 1'b1, 8'h00);
    expect_out("wrap_simul", 0, 8'h61, 1'b1, 1'b1);
    idle_stat("wrap_after", 8'h24, 1'b1, 1'b1);
    wrap_exp[0] = 8'h72; wrap_exp[1] = 8'h83; wrap_exp[2] = 8'h94; wrap_exp[3] = 8'hC7;
    for (int k = 0; k < 4; k++) pop_exp("wrap_drain", k, wrap_exp[k]);
    idle_stat("wrap_empty", 8'h10, 1'b1, 1'b0);

    // Reset with three bytes buffered, then whitening is back on by default.
    send_byte(8'h01, "pre_rst"); send_byte(8'h02, "pre_rst"); send_byte(8'h03, "pre_rst");
    idle_stat("pre_rst_stat", 8'h03, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_out("in_rst_stat", 0, 8'h10, 1'b1, 1'b0);
    address = 4'd0;
    #1;
    chk8("in_rst_data", 0, data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
      expect_out("post_rst_bits", i, 8'h10, 1'b1, 1'b0);
    end
    idle_stat("post_rst_stat", 8'h01, 1'b1, 1'b1);
    pop_exp("post_rst_pop", 0, 8'hFF);
    idle_stat("post_rst_empty", 8'h10, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
